// File: rtl/op_select.sv
// Operation-select front end: synchronises and debounces the confirm button,
// validates the operation switches on a confirmed press and latches op_type.
module op_select #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] sw_op,
  input  logic       btn_confirm,
  output logic [3:0] op_type,
  output logic       op_valid,
  output logic       op_err,
  output logic       locked
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {
    SEL    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  logic          sync1;
  logic          btn_s;
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] cnt;
  logic          press;
  logic          legal;

  state_t        state;
  state_t        state_n;
  logic [3:0]    op_type_n;
  logic          op_valid_n;
  logic          op_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_confirm;
      btn_s <= sync1;
    end
  end

  // btn_db only follows btn_s after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      cnt      <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s != btn_db) begin
        if (cnt == CNT_MAX) begin
          btn_db <= btn_s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  always_comb begin
    legal = 1'b0;
    case (sw_op)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
  end

  // op_valid / op_err are single-cycle, mutually exclusive pulses with no
  // back-pressure; op_type is stable whenever op_valid is high and until clr.
  always_comb begin
    state_n    = state;
    op_type_n  = op_type;
    op_valid_n = 1'b0;
    op_err_n   = 1'b0;
    case (state)
      SEL: begin
        if (clr) begin
          op_type_n = '0;
        end else if (press && en) begin
          if (legal) begin
            op_type_n  = sw_op;
            op_valid_n = 1'b1;
            state_n    = LOCKED;
          end else begin
            op_err_n = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (clr) begin
          op_type_n = '0;
          state_n   = SEL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEL;
      op_type  <= '0;
      op_valid <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      state    <= state_n;
      op_type  <= op_type_n;
      op_valid <= op_valid_n;
      op_err   <= op_err_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
